// File: rtl/serial_pair_tx_pkg.sv
// Shared types and helpers for the serial pair transmitter (package serial_pkg).
// Channel encoding matches the lrclk level: 0 = left slot, 1 = right slot.
package serial_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_t;

  // Bits needed for a counter that runs 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_pair_tx_bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles, with one-clk
// strobes asserted in the cycle whose edge produces the rise or the fall.
module bclk_gen
  import serial_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int                W_DIV   = cnt_w(BCLK_DIV);
  localparam logic [W_DIV-1:0]  DIV_END = W_DIV'(BCLK_DIV - 1);

  logic [W_DIV-1:0] div_cnt;
  logic             tc;

  assign tc = (div_cnt == DIV_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Strobes lead the bclk register by one edge so that consumers update
  // their registers on the very edge that moves bclk.
  assign rise_stb = tc && !bclk && !rst;
  assign fall_stb = tc &&  bclk && !rst;

endmodule

// File: rtl/serial_pair_tx.sv
// Parallel operand pair to two-lane I2S-framed serial source (MSB first,
// one bclk delay after each lrclk edge). Build option SERIAL_PAIR_TX_HOLD_EN
// repeats the previous word pair on underrun instead of sending zeros.
module serial_pair_tx
  import serial_pkg::*;
#(
  parameter int W_DATA   = 32,
  parameter int W_SLOT   = 64,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_a,
  input  logic [W_DATA-1:0] in_b,
  output logic              bclk,
  output logic              lrclk,
  output logic              out_a,
  output logic              out_b,
  output logic              underrun
);

  localparam int               W_BIT  = cnt_w(W_SLOT);
  localparam logic [W_BIT-1:0] K_END  = W_BIT'(W_SLOT - 1);
  localparam logic [W_BIT-1:0] K_ONE  = W_BIT'(1);
  localparam logic [W_BIT-1:0] K_LAST = W_BIT'(W_DATA);

  if (W_DATA < 2) begin : g_chk_data
    $error("serial_pair_tx: W_DATA must be >= 2");
  end
  if (W_SLOT < W_DATA + 1) begin : g_chk_slot
    $error("serial_pair_tx: W_SLOT must be >= W_DATA + 1");
  end
  if (BCLK_DIV < 1) begin : g_chk_div
    $error("serial_pair_tx: BCLK_DIV must be >= 1");
  end

  logic              rise_stb;
  logic              fall_stb;
  logic              unused_rise;
  ch_t               ch;
  logic [W_BIT-1:0]  bit_cnt;
  logic [W_BIT-1:0]  k_next;
  logic              load_stb;
  logic              xfer;
  logic              hold_full;
  logic [W_DATA-1:0] hold_a;
  logic [W_DATA-1:0] hold_b;
  logic [W_DATA-1:0] sh_a;
  logic [W_DATA-1:0] sh_b;
  logic [W_DATA-1:0] load_a;
  logic [W_DATA-1:0] load_b;

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst      (rst),
    .bclk     (bclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Nothing in the framing reacts to the rising edge.
  assign unused_rise = rise_stb;

  assign k_next   = (bit_cnt == K_END) ? '0 : bit_cnt + 1'b1;
  assign load_stb = fall_stb && (k_next == K_ONE);
  assign in_ready = !hold_full && !rst;
  assign xfer     = in_valid && in_ready;
  assign lrclk    = ch;

`ifdef SERIAL_PAIR_TX_HOLD_EN
  logic [W_DATA-1:0] last_a;
  logic [W_DATA-1:0] last_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_a <= '0;
      last_b <= '0;
    end else if (load_stb && hold_full) begin
      last_a <= hold_a;
      last_b <= hold_b;
    end
  end

  always_comb begin
    load_a = last_a;
    load_b = last_b;
    if (hold_full) begin
      load_a = hold_a;
      load_b = hold_b;
    end
  end
`else
  always_comb begin
    load_a = '0;
    load_b = '0;
    if (hold_full) begin
      load_a = hold_a;
      load_b = hold_b;
    end
  end
`endif

  // Holding register: freed on the load edge, so a new word can only land
  // from the following clk onwards and then waits for the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_a    <= '0;
      hold_b    <= '0;
    end else if (load_stb && hold_full) begin
      hold_full <= 1'b0;
    end else if (xfer) begin
      hold_full <= 1'b1;
      hold_a    <= in_a;
      hold_b    <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch       <= CH_RIGHT;
      bit_cnt  <= K_END;
      sh_a     <= '0;
      sh_b     <= '0;
      out_a    <= 1'b0;
      out_b    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall_stb) begin
        bit_cnt <= k_next;
        if (k_next == '0) begin
          ch <= (ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end
        // The MSB leaves on the load edge itself, straight from the new word.
        if (load_stb) begin
          out_a    <= load_a[W_DATA-1];
          out_b    <= load_b[W_DATA-1];
          sh_a     <= {load_a[W_DATA-2:0], 1'b0};
          sh_b     <= {load_b[W_DATA-2:0], 1'b0};
          underrun <= !hold_full;
        end else if ((k_next != '0) && (k_next <= K_LAST)) begin
          out_a <= sh_a[W_DATA-1];
          out_b <= sh_b[W_DATA-1];
          sh_a  <= {sh_a[W_DATA-2:0], 1'b0};
          sh_b  <= {sh_b[W_DATA-2:0], 1'b0};
        end else begin
          out_a <= 1'b0;
          out_b <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_pair_tx.sv
// Randomized bench for serial_pair_tx with a slot-level timing/data model;
// honours SERIAL_PAIR_TX_HOLD_EN for the underrun payload.
module tb_serial_pair_tx;

  localparam int WD = 8;
  localparam int WS = 10;
  localparam int BD = 2;
  localparam int P  = 2 * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [WD-1:0] in_a = '0;
  logic [WD-1:0] in_b = '0;
  logic          in_ready;
  logic          bclk;
  logic          lrclk;
  logic          out_a;
  logic          out_b;
  logic          underrun;

  always #5 clk = ~clk;

  serial_pair_tx #(
    .W_DATA   (WD),
    .W_SLOT   (WS),
    .BCLK_DIV (BD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .out_a    (out_a),
    .out_b    (out_b),
    .underrun (underrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: clk edges since reset release, one held pair, current slot word.
  int          cyc;
  bit          held;
  bit          ur;
  int          n_acc;
  logic [7:0]  h_a, h_b, c_a, c_b, l_a, l_b;
  bit          cap_en;
  logic [7:0]  cap_a, cap_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    cyc  = 0;
    held = 0;
    ur   = 0;
    c_a  = '0;
    c_b  = '0;
    l_a  = '0;
    l_b  = '0;
  endtask

  function automatic int cur_k();
    int nf;
    nf = cyc / P;
    return (nf == 0) ? -1 : (nf - 1) % WS;
  endfunction

  function automatic int cur_slot();
    int nf;
    nf = cyc / P;
    return (nf == 0) ? -1 : (nf - 1) / WS;
  endfunction

  // Called at a negedge: drive inputs, check outputs, advance one clk.
  task automatic tick(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b);
    int  k, slot;
    bit  lr;
    bit  rdy;
    logic ea, eb;
    rst = r; in_valid = v; in_a = a; in_b = b;
    #1;
    k    = cur_k();
    slot = cur_slot();
    lr   = (slot < 0) ? 1'b1 : bit'(slot % 2);
    ea   = (k >= 1 && k <= WD) ? c_a[WD-k] : 1'b0;
    eb   = (k >= 1 && k <= WD) ? c_b[WD-k] : 1'b0;
    check_eq("bclk", 32'(bclk), 32'((cyc / BD) % 2));
    check_eq("lrclk", 32'(lrclk), 32'(lr));
    check_eq("out_a", 32'(out_a), 32'(ea));
    check_eq("out_b", 32'(out_b), 32'(eb));
    check_eq("underrun", 32'(underrun), 32'(ur));
    check_eq("in_ready", 32'(in_ready), 32'(!r && !held));
    if (cap_en && cyc > 0 && (cyc % P) == 0 && slot == 0 && k >= 1 && k <= WD) begin
      cap_a = {cap_a[6:0], out_a};
      cap_b = {cap_b[6:0], out_b};
    end
    @(posedge clk);
    if (r) begin
      reset_model();
    end else begin
      rdy = !held;
      cyc++;
      ur  = 0;
      if ((cyc % P) == 0 && ((cyc / P) - 1) % WS == 1) begin
        if (held) begin
          c_a = h_a; c_b = h_b;
          l_a = h_a; l_b = h_b;
          held = 0;
        end else begin
`ifdef SERIAL_PAIR_TX_HOLD_EN
          c_a = l_a; c_b = l_b;
`else
          c_a = '0;  c_b = '0;
`endif
          ur = 1;
        end
      end
      if (v && rdy) begin
        h_a = a; h_b = b;
        held = 1;
        n_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    bit found;
    reset_model();
    cap_en = 0;
    @(negedge clk);

    // Reset, then one word A5/3C followed by an underrun right slot.
    do_reset(5);
    cap_a = '0; cap_b = '0; cap_en = 1;
    tick(1'b0, 1'b1, 8'hA5, 8'h3C);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);
    cap_en = 0;
    check_eq("left_word_a", 32'(cap_a), 32'h A5);
    check_eq("left_word_b", 32'(cap_b), 32'h 3C);

    // Backpressure: valid held high across four incrementing pairs.
    do_reset(2);
    n_acc = 0;
    for (int i = 0; i < 400 && n_acc < 4; i++)
      tick(1'b0, 1'b1, 8'(n_acc), 8'(8'h10 + n_acc));
    check_eq("bp_accepts", 32'(n_acc), 32'd4);
    for (int i = 0; i < 200; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);

    // Random traffic with random valid density.
    do_reset(2);
    for (int i = 0; i < 2000; i++)
      tick(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));

    // Reset at k=4 of a left slot with a word waiting in the holding register.
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick(1'b0, 1'b1, 8'($urandom), 8'($urandom));
      if (cur_k() == 4 && (cur_slot() % 2) == 0 && held) found = 1;
    end
    check_eq("midrst_reached", 32'(found), 32'd1);
    do_reset(2);
    for (int i = 0; i < 120; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 300; i++)
      tick(1'b0, ($urandom_range(0, 1) != 0), 8'($urandom), 8'($urandom));

    // Serial adder hook-up: reassembled lane words give 3+5 and 3-5.
    do_reset(3);
    cap_a = '0; cap_b = '0; cap_en = 1;
    tick(1'b0, 1'b1, 8'd3, 8'd5);
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);
    cap_en = 0;
    check_eq("adder_sum", 32'(8'(cap_a + cap_b)), 32'h08);
    check_eq("adder_diff", 32'(8'(cap_a - cap_b)), 32'hFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_pair_tx.md
Name: serial_pair_tx

Overview:
- Upstream source stage for the bit-serial arithmetic units.
- Generates bclk and lrclk from the system clock.
- Accepts parallel operand pairs over a valid/ready handshake and serializes them MSB-first on two lanes, out_a and out_b, in I2S framing (one-bclk delay after each lrclk edge).
- Drives the in_a, in_b, bclk and lrclk inputs of the serial adder/subtractor and of the other serial datapath blocks.

Parameters:
- W_DATA, 32, bits per operand word; must be >= 2.
- W_SLOT, 64, bclk periods per lrclk half-period (channel slot); must be >= W_DATA + 1.
- BCLK_DIV, 4, clk cycles per bclk half-period; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  holding register free.
- in_a  in  W_DATA  lane A operand.
- in_b  in  W_DATA  lane B operand.
- bclk  out  1  bit clock.
- lrclk  out  1  channel clock; 0 = left slot, 1 = right slot.
- out_a  out  1  lane A serial data.
- out_b  out  1  lane B serial data.
- underrun  out  1  one-clk pulse when a slot starts with no word available.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All outputs are registered except in_ready.
- Reset values: bclk=0, lrclk=1, out_a=0, out_b=0, underrun=0, div_cnt=0, bit_cnt=W_SLOT-1, holding register empty. in_ready is 0 while rst is high.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - On the terminal count bclk toggles and div_cnt wraps.
  - Rise = 0->1 toggle; fall = 1->0 toggle. The first fall occurs 2*BCLK_DIV clks after rst deasserts.
- All data and lrclk changes occur only in the clk cycle where bclk falls, registered together with bclk. Nothing changes on rise.
- Slot counter:
  - On each fall, k = (bit_cnt == W_SLOT-1) ? 0 : bit_cnt+1, and bit_cnt <= k.
  - When k == 0, lrclk toggles. The first fall after reset therefore gives lrclk=0 (left).
- Output mapping on fall with index k:
  - 1 <= k <= W_DATA: out_a/out_b <= shift-register bit W_DATA-k (MSB at k=1).
  - Otherwise: out_a/out_b <= 0.
  - A consumer sampling on the bclk rise sees lrclk change one rise before the MSB.
- Load at k == 1:
  - Holding register full: its contents move into the lane shift registers and the register is freed that same cycle.
  - Holding register empty: the shift registers are loaded with 0 and underrun pulses high for exactly that clk.
- Handshake:
  - in_ready = !hold_full && !rst.
  - Transfer occurs when in_valid && in_ready on a clk edge.
  - in_a/in_b are captured into the holding register.
  - No transfer is possible in the load cycle (in_ready is low there).
  - A word arriving after k=1 waits for the next slot.
- Slot ordering: words strictly alternate left, right, left, ... in acceptance order. There is no channel tag.
- Throughput: one word pair per W_SLOT bclk periods. Up-stream sees backpressure only.
- Reset mid-slot: all state returns to reset values immediately; the partially sent word and any held word are discarded; the next frame starts cleanly at left.

Optional Feature:
- Macro: SERIAL_PAIR_TX_HOLD_EN.
- Defined: on underrun, the shift registers reload the last transmitted word pair (the previous slot's word, held across channels) instead of zero. underrun still pulses. The last-word register resets to 0.
- Undefined: zeros are sent on underrun; no last-word register exists.

Decomposition:
- Package serial_pkg:
  - typedef enum logic {CH_LEFT=1'b0, CH_RIGHT=1'b1} ch_t.
  - A width helper function for the counters (clog2-based).
- Sub-module bclk_gen:
  - Parameter BCLK_DIV; ports clk, rst.
  - Outputs bclk and one-clk strobes rise_stb and fall_stb.
- All framing, handshake and shift logic lives in serial_pair_tx.

Test Plan (W_DATA=8, W_SLOT=10, BCLK_DIV=2 unless noted):
- Reset: hold rst 5 clks -> bclk=0, lrclk=1, outs=0, in_ready=0; after release in_ready=1. First fall at clk 4 -> lrclk=0.
- Single word a=8'hA5, b=8'h3C accepted before the first fall:
  - out_a sequence at k=1..8 is 1,0,1,0,0,1,0,1; out_b is 0,0,1,1,1,1,0,0.
  - k=0 and k=9 give 0; underrun stays 0 for the left slot.
- Underrun: no second word -> right slot (lrclk=1) carries all zeros and underrun is exactly one clk high at its k=1. With SERIAL_PAIR_TX_HOLD_EN defined, it carries A5/3C instead.
- Backpressure: in_valid held high with 4 incrementing pairs:
  - in_ready drops after each accept and rises the clk after each k=1 load.
  - Slots carry the pairs in order L0, R1, L2, R3 with no underrun.
- Reset mid-slot: assert rst at k=4 of a left slot -> outputs reset next clk; after release the first slot is left and the held word has been discarded.
- Integration with the serial adder (w_sum=8), a=8'd3, b=8'd5, minus inputs 0 -> its parallel result reads 8'd8 after the slot; repeat with minus_b=1 -> 8'hFE.
